// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
package seq_det_pkg;

    // Detector progress: how much of the 1-0-1-1 prefix has been seen.
    typedef enum logic [2:0] {
        IDLE,
        S1,
        S10,
        S101,
        S1011
    } state_t;

    // Target pattern, oldest bit in the MSB.
    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector_1011.sv
// Moore FSM detecting 1-0-1-1 on a serial stream, with a saturating match counter.
module seq_detector_1011
    import seq_det_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] det_count
);

    state_t state;

    // Longest pattern prefix that is a suffix of (matched prefix + new bit).
    function automatic state_t next_state(input state_t cur, input logic bit_in);
        case (cur)
            IDLE:    return bit_in ? S1    : IDLE;
            S1:      return bit_in ? S1    : S10;
            S10:     return bit_in ? S101  : IDLE;
            S101:    return bit_in ? S1011 : S10;
            S1011: begin
                if (OVERLAP != 0)
                    return bit_in ? S1 : S10;
                else
                    return bit_in ? S1 : IDLE;
            end
            default: return IDLE;
        endcase
    endfunction

    // State register, registered detect flag and saturating match counter.
    // z is registered from the next-state value so it is high exactly while state==S1011.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            z         <= 1'b0;
            det_count <= '0;
        end else begin
            state <= next_state(state, x);
            z     <= (next_state(state, x) == S1011);
            if ((next_state(state, x) == S1011) && (det_count != '1))
                det_count <= det_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detector_1011.sv
// Scoreboard bench: three detector instances (overlap, non-overlap, 2-bit counter)
// driven by a common stream and checked against a sliding-window reference model.
module tb_seq_detector_1011;
    import seq_det_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x   = 1'b0;
    logic       z_ov, z_nov, z_sat;
    logic [7:0] c_ov, c_nov;
    logic [1:0] c_sat;

    always #5 clk = ~clk;

    seq_detector_1011 #(.OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .x(x), .z(z_ov), .det_count(c_ov)
    );
    seq_detector_1011 #(.OVERLAP(0), .CNT_W(8)) dut_nov (
        .clk(clk), .rst(rst), .x(x), .z(z_nov), .det_count(c_nov)
    );
    seq_detector_1011 #(.OVERLAP(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .x(x), .z(z_sat), .det_count(c_sat)
    );

    typedef struct {
        bit z_ov;
        bit z_nov;
        bit z_sat;
        int c_ov;
        int c_nov;
        int c_sat;
    } exp_t;

    exp_t exp_q[$];
    bit   h_ov[$];
    bit   h_nov[$];
    int   m_ov  = 0;
    int   m_nov = 0;
    int   m_sat = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // True when the last four bits of the history equal the pattern.
    function automatic bit ends_with_pattern(input bit h[$]);
        logic [3:0] p;
        int unsigned n;
        p = PATTERN;
        n = h.size();
        if (n < 4) return 1'b0;
        return (h[n-4] == p[3]) && (h[n-3] == p[2]) && (h[n-2] == p[1]) && (h[n-1] == p[0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bit (or a reset cycle) and queue the response expected after the next edge.
    task automatic step(input bit r, input bit b);
        exp_t e;
        bit   hit_ov, hit_nov;
        @(negedge clk);
        rst = r;
        x   = b;
        if (!r) begin
            h_ov.delete();
            h_nov.delete();
            m_ov  = 0;
            m_nov = 0;
            m_sat = 0;
            e = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
        end else begin
            h_ov.push_back(b);
            h_nov.push_back(b);
            if (h_ov.size() > 4) void'(h_ov.pop_front());
            if (h_nov.size() > 4) void'(h_nov.pop_front());
            hit_ov  = ends_with_pattern(h_ov);
            hit_nov = ends_with_pattern(h_nov);
            // Non-overlapping: bits of a completed match never contribute to the next one.
            if (hit_nov) h_nov.delete();
            if (hit_ov) begin
                if (m_ov < 255) m_ov++;
                if (m_sat < 3) m_sat++;
            end
            if (hit_nov && m_nov < 255) m_nov++;
            e = '{hit_ov, hit_nov, hit_ov, m_ov, m_nov, m_sat};
        end
        exp_q.push_back(e);
    endtask

    task automatic run_seq(input bit s[$]);
        foreach (s[i]) step(1'b1, s[i]);
    endtask

    // Monitor: after every rising edge compare DUT outputs with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("z_ov",   32'(z_ov),  int'(e.z_ov));
                check("z_nov",  32'(z_nov), int'(e.z_nov));
                check("z_sat",  32'(z_sat), int'(e.z_sat));
                check("cnt_ov",  32'(c_ov),  e.c_ov);
                check("cnt_nov", 32'(c_nov), e.c_nov);
                check("cnt_sat", 32'(c_sat), e.c_sat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit s_overlap[$] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bit s_prefix[$]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit s_mid[$]     = '{1'b1, 1'b0, 1'b1};
        bit s_pat[$]     = '{1'b1, 1'b0, 1'b1, 1'b1};

        // Outputs cleared while reset is held from time zero.
        #1;
        check("init_z_ov",  32'(z_ov),  0);
        check("init_cnt_ov", 32'(c_ov), 0);

        // Reset held with random data.
        repeat (3) step(1'b0, 1'($urandom_range(0, 1)));

        // Overlap stream: two matches with overlap, one without.
        run_seq(s_overlap);
        step(1'b0, 1'b0);

        // False-prefix recovery.
        run_seq(s_prefix);
        step(1'b0, 1'b0);

        // Reset in the middle of a match discards progress.
        run_seq(s_mid);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Counter saturation on the 2-bit instance.
        repeat (5) run_seq(s_pat);
        step(1'b0, 1'b0);

        // Asynchronous reset between edges while z is high.
        run_seq(s_pat);
        @(posedge clk);
        #2;
        check("pre_async_z", 32'(z_ov), 1);
        rst = 1'b0;
        #1;
        check("async_z_ov",    32'(z_ov),  0);
        check("async_z_nov",   32'(z_nov), 0);
        check("async_cnt_ov",  32'(c_ov),  0);
        check("async_cnt_nov", 32'(c_nov), 0);
        check("async_cnt_sat", 32'(c_sat), 0);
        step(1'b0, 1'b0);

        // Random stream with occasional resets.
        repeat (400) step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)));
        step(1'b1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
